// File: rtl/sdio_cmd_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdio_cmd_host_if
//  Description : Pipelined Wishbone bus bundle for the SD/SDIO command-path
//                host. The bus master drives cyc/stb/we/addr/data/sel. The
//                slave returns stall/ack/data.
//  Ports       : i_wb_cyc, i_wb_stb, i_wb_we   bus control (master -> slave)
//                i_wb_addr[2:0]                 word address
//                i_wb_data[31:0], i_wb_sel[3:0] write data, byte enables
//                o_wb_stall, o_wb_ack           slave handshake
//                o_wb_data[31:0]                registered read data
//  Revision    : 1.0  initial release
// ============================================================================
interface sdio_cmd_host_if;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic        i_wb_we;
   logic [2:0]  i_wb_addr;
   logic [31:0] i_wb_data;
   logic [3:0]  i_wb_sel;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_data
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface
`default_nettype wire

// File: rtl/sdio_cmd_host.sv
`default_nettype none
// ============================================================================
//  Module      : sdio_cmd_host
//  Description : SD/SDIO host controller, command path only. It generates a
//                programmable SD clock and sends 48-bit commands on CMD. It
//                captures 48-bit responses with a CRC7 and end-bit check and a
//                response timeout. The data lines are left high-Z.
//  Ports       : i_clk, i_reset     system clock, synchronous active-high reset
//                wb (slave)         Wishbone register port (CMD/ARG/PHY)
//                o_ck               SD clock
//                io_cmd             CMD line, driven only while sending
//                io_dat[NUMIO-1:0]  data lines, always released
//                i_card_detect      card present (active high)
//                o_int              done & interrupt enable
//                o_debug[31:0]      {busy, state, cmd out, cmd sample, 0}
//  Options     : `define SDIO_CARD_DETECT_EN to refuse commands when no card
//                is present. A refused command flags err and done. In this
//                build CMD[19] reads back !i_card_detect.
//  Revision    : 1.0  initial release
// ============================================================================
module sdio_cmd_host #(
   parameter int NUMIO     = 4,
   parameter int LGTIMEOUT = 10,
   parameter int DIVRST    = 124
) (
   input  wire               i_clk,
   input  wire               i_reset,
   sdio_cmd_host_if.slave    wb,
   output logic              o_ck,
   inout  wire               io_cmd,
   inout  wire [NUMIO-1:0]   io_dat,
   input  wire               i_card_detect,
   output logic              o_int,
   output logic [31:0]       o_debug
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEND = 3'd1,
      S_WAIT = 3'd2,
      S_RECV = 3'd3
   } state_t;

   localparam logic [5:0] c_TX_DONE = 6'd48;   // all 48 bits have been driven
   localparam logic [5:0] c_RX_LAST = 6'd46;   // index of the final shift after the start bit

   // CRC7, x^7 + x^3 + 1, init 0, MSB first
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   state_t                r_state, w_next;
   logic [7:0]            r_div, r_div_act, r_cnt;
   logic                  r_ck;
   logic                  r_busy, r_done, r_err, r_timeout, r_inten;
   logic [5:0]            r_idx;
   logic [1:0]            r_type;
   logic [31:0]           r_arg;
   logic [47:0]           r_frame;
   logic [5:0]            r_bitcnt, r_rxcnt;
   logic                  r_oe, r_cmd_out, r_sample;
   logic [LGTIMEOUT-1:0]  r_to;
   logic [46:0]           r_rx;
   logic                  r_ack;
   logic [31:0]           r_rdata;

   // ---------------- SD clock: the divider reloads only at a toggle --------
   wire w_tick = (r_cnt == r_div_act);
   wire w_fall = w_tick &  r_ck;
   wire w_rise = w_tick & ~r_ck;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_ck      <= 1'b0;
         r_div_act <= 8'(DIVRST);
      end else if (w_tick) begin
         r_cnt     <= '0;
         r_ck      <= ~r_ck;
         r_div_act <= r_div;
      end else begin
         r_cnt     <= r_cnt + 8'd1;
      end
   end

   // ---------------- Bus decode ----------------
   wire w_req    = wb.i_wb_cyc & wb.i_wb_stb;
   wire w_wr     = w_req & wb.i_wb_we;
   wire w_cmd_wr = w_wr & (wb.i_wb_addr == 3'd0);
   // bit 18 on an idle CMD write acknowledges the interrupt instead of starting
   wire w_clr    = w_cmd_wr & ~r_busy &  wb.i_wb_data[18];
   wire w_cmd_go = w_cmd_wr & ~r_busy & ~wb.i_wb_data[18];

   logic w_start, w_nocard, w_cd_bit;
`ifdef SDIO_CARD_DETECT_EN
   assign w_start  = w_cmd_go &  i_card_detect;
   assign w_nocard = w_cmd_go & ~i_card_detect;
   assign w_cd_bit = ~i_card_detect;
`else
   assign w_start  = w_cmd_go;
   assign w_nocard = 1'b0;
   assign w_cd_bit = 1'b0;
`endif

   wire [39:0] w_tx_head  = {2'b01, wb.i_wb_data[5:0], r_arg};
   wire [47:0] w_tx_frame = {w_tx_head, crc7(w_tx_head), 1'b1};
   wire [47:0] w_rx_next  = {r_rx, io_cmd};
   wire        w_rx_bad   = ~w_rx_next[0] |
                            ((r_type != 2'b10) && (crc7(w_rx_next[47:8]) != w_rx_next[7:1]));

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   logic w_send_bit, w_send_end, w_rx_start, w_rx_shift, w_rx_done, w_timeout, w_to_inc;

   always_comb begin
      w_next     = r_state;
      w_send_bit = 1'b0;
      w_send_end = 1'b0;
      w_rx_start = 1'b0;
      w_rx_shift = 1'b0;
      w_rx_done  = 1'b0;
      w_timeout  = 1'b0;
      w_to_inc   = 1'b0;
      case (r_state)
         S_IDLE: if (w_start) w_next = S_SEND;
         S_SEND: if (w_fall) begin
            if (r_bitcnt == c_TX_DONE) begin
               // end bit's period is over: release the line
               w_send_end = 1'b1;
               w_next     = (r_type == 2'b00) ? S_IDLE : S_WAIT;
            end else begin
               w_send_bit = 1'b1;
            end
         end
         S_WAIT: if (w_rise) begin
            if (!io_cmd) begin
               w_rx_start = 1'b1;
               w_next     = S_RECV;
            end else if (&r_to) begin
               w_timeout  = 1'b1;
               w_next     = S_IDLE;
            end else begin
               w_to_inc   = 1'b1;
            end
         end
         S_RECV: if (w_rise) begin
            w_rx_shift = 1'b1;
            if (r_rxcnt == c_RX_LAST) begin
               w_rx_done = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- Datapath and registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_div     <= 8'(DIVRST);
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         r_inten   <= 1'b0;
         r_idx     <= '0;
         r_type    <= '0;
         r_arg     <= '0;
         r_frame   <= '0;
         r_bitcnt  <= '0;
         r_rxcnt   <= '0;
         r_oe      <= 1'b0;
         r_cmd_out <= 1'b1;
         r_sample  <= 1'b1;
         r_to      <= '0;
         r_rx      <= '0;
         r_ack     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if (w_cmd_wr)                          r_inten <= wb.i_wb_data[15];
         if (w_wr && wb.i_wb_addr == 3'd1)      r_arg   <= wb.i_wb_data;
         if (w_wr && wb.i_wb_addr == 3'd2)      r_div   <= wb.i_wb_data[7:0];
         if (w_clr) r_done <= 1'b0;
         if (w_nocard) begin
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
         end
         if (w_start) begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_idx     <= wb.i_wb_data[5:0];
            r_type    <= wb.i_wb_data[9:8];
            r_frame   <= w_tx_frame;
            r_bitcnt  <= '0;
         end
         if (w_send_bit) begin
            r_oe      <= 1'b1;
            r_cmd_out <= r_frame[47];
            r_frame   <= {r_frame[46:0], 1'b0};
            r_bitcnt  <= r_bitcnt + 6'd1;
         end
         if (w_send_end) begin
            r_oe      <= 1'b0;
            r_cmd_out <= 1'b1;
            r_to      <= '0;
            if (r_type == 2'b00) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
         if (w_rise)   r_sample <= io_cmd;
         if (w_to_inc) r_to     <= r_to + LGTIMEOUT'(1);
         if (w_timeout) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
         end
         // the start bit is already known to be 0; it ends up at bit 47
         if (w_rx_start) begin
            r_rx    <= '0;
            r_rxcnt <= '0;
         end
         if (w_rx_shift) begin
            r_rx    <= w_rx_next[46:0];
            r_rxcnt <= r_rxcnt + 6'd1;
         end
         if (w_rx_done) begin
            r_err  <= w_rx_bad;
            r_idx  <= w_rx_next[45:40];
            r_arg  <= w_rx_next[39:8];
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
         r_ack <= w_req;
         if (w_req) begin
            case (wb.i_wb_addr)
               3'd0:    r_rdata <= {12'b0, w_cd_bit, r_done, r_timeout, r_err, r_inten,
                                    r_busy, 4'b0, r_type, 2'b0, r_idx};
               3'd1:    r_rdata <= r_arg;
               3'd2:    r_rdata <= {24'b0, r_div};
               default: r_rdata <= '0;
            endcase
         end
      end
   end

   assign wb.o_wb_stall = 1'b0;
   assign wb.o_wb_ack   = r_ack;
   assign wb.o_wb_data  = r_rdata;
   assign o_ck          = r_ck;
   assign o_int         = r_done & r_inten;
   assign o_debug       = {r_busy, r_state, r_cmd_out, r_sample, 26'b0};
   assign io_cmd        = r_oe ? r_cmd_out : 1'bz;
   assign io_dat        = {NUMIO{1'bz}};

   wire w_unused = &{1'b0, wb.i_wb_sel, i_card_detect, io_dat};

endmodule
`default_nettype wire

// File: tb/tb_sdio_cmd_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdio_cmd_host
//  Description : Directed bench for sdio_cmd_host. It has a Wishbone master,
//                a frame sniffer on CMD, and a simple card responder. CMD has
//                a pull-up, so a released line reads 1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdio_cmd_host;
   logic        clk;
   logic        rst;
   logic        card_detect;
   logic        card_oe;
   logic        card_val;
   logic        o_ck;
   logic        o_int;
   logic [31:0] o_debug;
   wire         io_cmd;
   wire  [3:0]  io_dat;
   int          n_checks;
   int          n_errors;

   sdio_cmd_host_if wb_if();

   pullup (io_cmd);
   assign io_cmd = card_oe ? card_val : 1'bz;

   sdio_cmd_host #(.NUMIO(4), .LGTIMEOUT(10), .DIVRST(124)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .wb            (wb_if),
      .o_ck          (o_ck),
      .io_cmd        (io_cmd),
      .io_dat        (io_dat),
      .i_card_detect (card_detect),
      .o_int         (o_int),
      .o_debug       (o_debug)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      wb_if.i_wb_cyc  = 1'b1;
      wb_if.i_wb_stb  = 1'b1;
      wb_if.i_wb_we   = 1'b1;
      wb_if.i_wb_addr = a;
      wb_if.i_wb_data = d;
      @(negedge clk);
      wb_if.i_wb_cyc  = 1'b0;
      wb_if.i_wb_stb  = 1'b0;
      wb_if.i_wb_we   = 1'b0;
   endtask

   task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      wb_if.i_wb_cyc  = 1'b1;
      wb_if.i_wb_stb  = 1'b1;
      wb_if.i_wb_we   = 1'b0;
      wb_if.i_wb_addr = a;
      @(negedge clk);
      d = wb_if.o_wb_ack ? wb_if.o_wb_data : 32'hDEAD_BEEF;
      wb_if.i_wb_cyc  = 1'b0;
      wb_if.i_wb_stb  = 1'b0;
   endtask

   // Sniff 48 bits on CMD at SD clock rising edges, beginning with the start bit
   task automatic capture_frame(output logic [47:0] f);
      int   got;
      logic prev;
      f = '0; got = 0; prev = o_ck;
      for (int n = 0; n < 3000 && got < 48; n++) begin
         @(negedge clk);
         if (o_ck && !prev && (got > 0 || io_cmd == 1'b0)) begin
            f = {f[46:0], io_cmd};
            got++;
         end
         prev = o_ck;
      end
      if (got != 48) f = '1;
   endtask

   task automatic wait_falls(input int k);
      int   seen;
      logic prev;
      seen = 0; prev = o_ck;
      for (int n = 0; n < 1000 && seen < k; n++) begin
         @(negedge clk);
         if (!o_ck && prev) seen++;
         prev = o_ck;
      end
   endtask

   // Card: hold off two SD clocks, then drive each bit from one falling edge to the next
   task automatic card_reply(input logic [47:0] r);
      wait_falls(2);
      for (int b = 47; b >= 0; b--) begin
         card_oe  = 1'b1;
         card_val = r[b];
         wait_falls(1);
      end
      card_oe = 1'b0;
   endtask

   task automatic wait_done(output logic [31:0] v);
      v = '0;
      for (int n = 0; n < 300; n++) begin
         wb_read(3'd0, v);
         if (v[18]) break;
      end
   endtask

   initial begin
      logic [31:0] v;
      logic [47:0] f;
      logic        prev;
      int          first, second;
      n_checks = 0; n_errors = 0;
      card_detect = 1'b1; card_oe = 1'b0; card_val = 1'b1;
      wb_if.i_wb_cyc = 1'b0; wb_if.i_wb_stb = 1'b0; wb_if.i_wb_we = 1'b0;
      wb_if.i_wb_addr = '0; wb_if.i_wb_data = '0; wb_if.i_wb_sel = 4'hF;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_ck",    o_ck, 1'b0);
      check("rst_ack",   wb_if.o_wb_ack, 1'b0);
      check("rst_rdata", wb_if.o_wb_data, 32'h0);
      check("rst_int",   o_int, 1'b0);
      check("rst_cmd_z", io_cmd, 1'b1);
      rst = 1'b0;

      wb_read(3'd0, v); check("rd_cmd_rst", v, 32'h0);
      wb_read(3'd1, v); check("rd_arg_rst", v, 32'h0);
      wb_read(3'd2, v); check("rd_phy_rst", v, 32'h7C);

      // SD clock period at the reset divider
      first = -1; second = -1; prev = o_ck;
      for (int n = 0; n < 700; n++) begin
         @(negedge clk);
         if (o_ck && !prev) begin
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
         prev = o_ck;
      end
      check("ck_period", second - first, 250);

      // CMD0, no response
      wb_write(3'd2, 32'd1);
      wb_write(3'd1, 32'h0);
      wb_write(3'd0, 32'h0000);
      wb_read(3'd0, v); check("cmd0_busy", v[14], 1'b1);
      capture_frame(f); check("cmd0_frame", f, 48'h4000_0000_0095);
      wait_done(v);
      check("cmd0_status", v, 32'h0004_0000);
      check("cmd0_state",  o_debug[30:28], 3'd0);
      check("cmd0_int",    o_int, 1'b0);

      // CMD8, R1 with good response
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h8108);
      capture_frame(f); check("cmd8_frame", f, 48'h4800_0001_AA87);
      card_reply(48'h0800_0001_AA13);
      wait_done(v);
      check("cmd8_status", v, 32'h0004_8108);
      wb_read(3'd1, v); check("cmd8_arg", v, 32'h0000_01AA);
      check("cmd8_int", o_int, 1'b1);
      wb_write(3'd0, 32'h0004_8000);
      check("int_clr", o_int, 1'b0);
      wb_read(3'd0, v); check("int_clr_status", v, 32'h0000_8108);

      // CMD8 with a silent card: 1024 SD clocks to timeout
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h8108);
      capture_frame(f); check("to_frame", f, 48'h4800_0001_AA87);
      repeat (4000) @(negedge clk);
      wb_read(3'd0, v); check("to_early", v[17:14], 4'b0011);
      wait_done(v);
      check("to_status", v, 32'h0006_8108);
      check("to_int", o_int, 1'b1);

      // Corrupted CRC: flagged for R1, accepted for R3
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h0108);
      capture_frame(f); check("crc1_frame", f, 48'h4800_0001_AA87);
      card_reply(48'h0800_0001_AA15);
      wait_done(v); check("crc_r1_status", v, 32'h0005_0108);
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h0208);
      capture_frame(f); check("crc3_frame", f, 48'h4800_0001_AA87);
      card_reply(48'h0800_0001_AA15);
      wait_done(v); check("crc_r3_status", v, 32'h0004_0208);
      wb_read(3'd1, v); check("crc_r3_arg", v, 32'h0000_01AA);

      // CMD write while busy only changes the interrupt enable
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h8108);
      wb_write(3'd0, 32'h0011);
      capture_frame(f); check("busy_wr_frame", f, 48'h4800_0001_AA87);
      card_reply(48'h0800_0001_AA13);
      wait_done(v); check("busy_wr_status", v, 32'h0004_0108);
      check("busy_wr_int", o_int, 1'b0);

      // Reset in the middle of a frame
      wb_write(3'd1, 32'h1AA);
      wb_write(3'd0, 32'h0108);
      first = 0;
      for (int n = 0; n < 200 && first == 0; n++) begin
         @(negedge clk);
         if (io_cmd == 1'b0) first = 1;
      end
      check("mid_start_seen", first, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_cmd_z", io_cmd, 1'b1);
      check("mid_rst_busy",  o_debug[31], 1'b0);
      check("mid_rst_ck",    o_ck, 1'b0);
      rst = 1'b0;
      wb_read(3'd0, v); check("mid_rst_cmd", v, 32'h0);
      wb_read(3'd1, v); check("mid_rst_arg", v, 32'h0);
      wb_read(3'd2, v); check("mid_rst_phy", v, 32'h7C);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/sdio_cmd_host.md
Name: sdio_cmd_host

Overview:
- Wishbone-slave SD/SDIO host controller reduced to the command path: programmable SD clock, 48-bit command transmission on CMD, 48-bit response capture with CRC7 check and timeout.
- Sits between the CPU bus and the SD card pins; data lines are not driven in this block.
- A data-path block attaches to the same pins elsewhere.

Parameters:
- NUMIO, 4, width of io_dat (1, 4 or 8); lines are held high-Z.
- LGTIMEOUT, 10, response timeout is 2^LGTIMEOUT SD clock periods.
- DIVRST, 124, reset value of the clock divider (100 MHz → 400 kHz).

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone pipelined control.
- i_wb_addr  in  3  word address.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte enables; full-word writes only, sel is ignored.
- o_wb_stall  out  1  tied to 0.
- o_wb_ack  out  1  acknowledge.
- o_wb_data  out  32  read data.
- o_ck  out  1  SD clock.
- io_cmd  inout  1  CMD line; drives 0/1 while transmitting, otherwise z.
- io_dat  inout  NUMIO  always z.
- i_card_detect  in  1  card present, active high.
- o_int  out  1  interrupt.
- o_debug  out  32  debug word.

Behaviour:
- Registers (address):
  - 0 CMD.
    - Write: [5:0] index, [9:8] response type (00 none, 01 R1 48-bit with CRC, 10 R3 48-bit with no CRC check, 11 treated as 01), [15] interrupt enable.
    - Read: [5:0] last index (response index after a response), [9:8] type, [14] busy, [15] int enable, [16] CRC/end-bit error, [17] timeout, [18] done.
  - 1 ARG: R/W command argument; after a response completes, holds response bits [39:8].
  - 2 PHY: [7:0] divider DIV; rest reads 0.
  - Other addresses read 0; writes to them are ignored.
- Wishbone:
  - o_wb_ack asserts exactly one cycle after i_wb_stb & i_wb_cyc.
  - o_wb_data is registered and valid with ack.
  - Writes take effect on the stb cycle.
- Clock: o_ck toggles every DIV+1 i_clk cycles, giving a period of 2·(DIV+1). It free-runs and starts low after reset. A divider write takes effect at the next toggle.
- Starting a command: a CMD write while not busy sets busy, clears done/err/timeout and loads the 48-bit frame:
  - 0, 1, index[5:0], ARG[31:0], CRC7, 1
  - CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
  - A CMD write while busy is ignored except bit 15.
- State machine IDLE → SEND → WAIT → RECV → IDLE:
  - SEND: each bit is driven on the i_clk cycle where o_ck falls; 48 bits MSB first; the line is released (z) after the end bit.
  - Type 00: SEND → IDLE; done sets when the end bit's period ends.
  - WAIT: io_cmd is sampled on o_ck rising edges. The first 0 is the start bit; go to RECV. After 2^LGTIMEOUT rising edges with no start bit, set timeout and done, then go to IDLE.
  - RECV: shift in 47 more bits on rising edges. At the end, check CRC7 over bits [47:8] (types 01/11) and end bit = 1. Mismatch sets err. Then load index and ARG, set done and clear busy.
- io_cmd is never driven in WAIT/RECV/IDLE.
- o_int = done & int enable. It is cleared by the next command start or by writing CMD with [18]=1 while idle (that write does not start a command).
- o_debug: [31] busy, [30:28] state, [27] cmd output bit, [26] sampled io_cmd, [25:0] 0.
- Reset, including mid-command:
  - State IDLE; busy, done, err, timeout, int enable = 0; ARG = 0; DIV = DIVRST.
  - o_ck = 0, io_cmd = z, o_wb_ack = 0, o_wb_data = 0, o_int = 0.

Optional Feature:
- SDIO_CARD_DETECT_EN:
  - Defined: a CMD write while i_card_detect = 0 does not start; it sets err and done instead. CMD read bit [19] = !i_card_detect.
  - Undefined: i_card_detect is ignored and bit [19] reads 0.

Test Plan:
- Reset, then read CMD, ARG and PHY → 0x0, 0x0, 0x7C. o_ck period is 250 i_clk cycles.
- Write PHY=1, ARG=0, CMD=0x0000 (CMD0, no response) → CMD line carries 0x400000000095; busy then done; no response wait; o_int stays 0.
- PHY=1, ARG=0x1AA, CMD=0x8108 (CMD8, R1, int enabled) → frame 0x48000001AA87. Card model replies 0x08000001AA13 → ARG=0x000001AA, index 8, err=0, o_int=1.
- Same command with responder silent → timeout=1 after 1024 SD clocks, done=1, err=0.
- Responder returns a corrupted CRC → err=1 for type 01; the same response with type 10 → err=0.
- Assert i_reset mid-SEND → io_cmd becomes z next cycle, busy=0. A second CMD write during busy leaves the in-flight frame unchanged.
